// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared video timing constants, colour-bar table, FSM states and pixel packing
//
// Contents:
//   VID_*         1920x1080p60 timing defaults (148.5 MHz pixel clock)
//   VID_BAR_RGB   colour-bar on/off flags, {r,g,b}, entry 0 = leftmost bar
//   vid_state_e   generator states IDLE / RUN / DRAIN
//   vid_pack      packs components into the stream order {red, blue, green}
package vid_pkg;

  localparam int VID_H_ACTIVE = 1920;
  localparam int VID_H_FP     = 88;
  localparam int VID_H_SYNC   = 44;
  localparam int VID_H_BP     = 148;
  localparam int VID_V_ACTIVE = 1080;
  localparam int VID_V_FP     = 4;
  localparam int VID_V_SYNC   = 5;
  localparam int VID_V_BP     = 36;

  localparam int VID_BARS = 8;

  // white, yellow, cyan, green, magenta, red, blue, black (index 0 first)
  localparam logic [VID_BARS-1:0][2:0] VID_BAR_RGB = {
    3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vid_state_e;

  function automatic logic [23:0] vid_pack(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {r, b, g};
  endfunction

endpackage

// File: rtl/vid_pattern_gen.sv
// rtl/vid_pattern_gen.sv - combinational test-pattern pixel for a given (h, v)
//
// Optional: VID_TIMING_GEN_CROSSHAIR_EN forces red on the centre row/column.
// Ports:
//   i_h      12  horizontal position
//   i_v      11  vertical position
//   i_sel     2  pattern: 0 bars, 1 grey ramp, 2 mid-grey, 3 64x64 checkerboard
//   o_pixel  24  packed pixel (unblanked; the parent applies blanking)
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = VID_H_ACTIVE
`ifdef VID_TIMING_GEN_CROSSHAIR_EN
  , parameter int V_ACTIVE = VID_V_ACTIVE
`endif
) (
  input  logic [11:0] i_h,
  input  logic [10:0] i_v,
  input  logic [1:0]  i_sel,
  output logic [23:0] o_pixel
);

  localparam int BAR_W = H_ACTIVE / VID_BARS;

  logic [2:0] w_bar;
  logic [2:0] w_rgb;
  logic       w_chk;

  // Bar index by threshold compare, avoiding a divider for non-power-of-2 widths.
  always_comb begin
    w_bar = '0;
    for (int k = 1; k < VID_BARS; k++) begin
      if (i_h >= 12'(k * BAR_W)) w_bar = 3'(k);
    end
  end

  assign w_rgb = VID_BAR_RGB[w_bar];
  assign w_chk = i_h[6] ^ i_v[6];

  always_comb begin
    o_pixel = '0;
    case (i_sel)
      2'd0:    o_pixel = vid_pack({8{w_rgb[2]}}, {8{w_rgb[1]}}, {8{w_rgb[0]}});
      2'd1:    o_pixel = vid_pack(i_h[10:3], i_h[10:3], i_h[10:3]);
      2'd2:    o_pixel = vid_pack(8'h80, 8'h80, 8'h80);
      default: o_pixel = vid_pack({8{w_chk}}, {8{w_chk}}, {8{w_chk}});
    endcase
`ifdef VID_TIMING_GEN_CROSSHAIR_EN
    if (i_h == 12'(H_ACTIVE / 2) || i_v == 11'(V_ACTIVE / 2)) begin
      o_pixel = vid_pack(8'hFF, 8'h00, 8'h00);
    end
`endif
  end

`ifndef VID_TIMING_GEN_CROSSHAIR_EN
  logic w_unused_v;
  assign w_unused_v = ^{i_v[10:7], i_v[5:0]};
`endif

endmodule

// File: rtl/vid_timing_gen.sv
// rtl/vid_timing_gen.sv - video timing generator with built-in test patterns
//
// Optional: VID_TIMING_GEN_CROSSHAIR_EN enables a red crosshair overlay.
// Ports:
//   clk            pixel clock
//   n_rst          asynchronous active-low reset
//   i_en           run request; frames always complete once started
//   sw[1:0]        pattern select, latched at the start of each frame
//   o_vid_data     24-bit pixel {R, B, G}, zero in blanking
//   o_vid_hsync    horizontal sync (polarity SYNC_POL)
//   o_vid_vsync    vertical sync (polarity SYNC_POL)
//   o_vid_VDE      data enable
//   o_hcount       horizontal position of the current beat
//   o_vcount       vertical position of the current beat
//   o_frame_start  one-beat pulse on (0,0)
//   o_busy         beat is valid (generator running or draining)
module vid_timing_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = VID_H_ACTIVE,
  parameter int H_FP     = VID_H_FP,
  parameter int H_SYNC   = VID_H_SYNC,
  parameter int H_BP     = VID_H_BP,
  parameter int V_ACTIVE = VID_V_ACTIVE,
  parameter int V_FP     = VID_V_FP,
  parameter int V_SYNC   = VID_V_SYNC,
  parameter int V_BP     = VID_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_en,
  input  logic [3:0]  sw,
  output logic [23:0] o_vid_data,
  output logic        o_vid_hsync,
  output logic        o_vid_vsync,
  output logic        o_vid_VDE,
  output logic [11:0] o_hcount,
  output logic [10:0] o_vcount,
  output logic        o_frame_start,
  output logic        o_busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  vid_state_e  r_state;
  vid_state_e  w_state_nxt;
  logic [11:0] r_h;
  logic [10:0] r_v;
  logic [1:0]  r_sel;

  logic        w_adv;
  logic        w_h_last;
  logic        w_frame_last;
  logic        w_origin;
  logic [1:0]  w_sel;
  logic        w_vde;
  logic        w_hs_act;
  logic        w_vs_act;
  logic [23:0] w_pixel;
  logic        w_unused_sw;

  assign w_adv        = (r_state != ST_IDLE);
  assign w_h_last     = (r_h == H_LAST);
  assign w_frame_last = w_h_last && (r_v == V_LAST);
  assign w_origin     = w_adv && (r_h == '0) && (r_v == '0);
  assign w_unused_sw  = ^sw[3:2];

  // The select is taken straight from sw on the (0,0) beat so that beat
  // already uses the new frame's pattern; r_sel holds it for the rest.
  assign w_sel = w_origin ? sw[1:0] : r_sel;

  assign w_vde    = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_act = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
  assign w_vs_act = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A request drop on the very last beat skips DRAIN, otherwise DRAIN would
  // start a whole new frame after the counters wrap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_en) w_state_nxt = ST_RUN;
      ST_RUN:   if (!i_en) w_state_nxt = w_frame_last ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (i_en)              w_state_nxt = ST_RUN;
        else if (w_frame_last) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_adv) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 11'd1;
      end else begin
        r_h <= r_h + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_sel <= '0;
    else        r_sel <= w_sel;
  end

  vid_pattern_gen #(
    .H_ACTIVE(H_ACTIVE)
`ifdef VID_TIMING_GEN_CROSSHAIR_EN
    , .V_ACTIVE(V_ACTIVE)
`endif
  ) u_pattern (
    .i_h    (r_h),
    .i_v    (r_v),
    .i_sel  (w_sel),
    .o_pixel(w_pixel)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_vid_data    <= '0;
      o_vid_hsync   <= !SYNC_POL;
      o_vid_vsync   <= !SYNC_POL;
      o_vid_VDE     <= 1'b0;
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
    end else if (w_adv) begin
      o_vid_data    <= w_vde ? w_pixel : '0;
      o_vid_hsync   <= w_hs_act ? SYNC_POL : !SYNC_POL;
      o_vid_vsync   <= w_vs_act ? SYNC_POL : !SYNC_POL;
      o_vid_VDE     <= w_vde;
      o_hcount      <= r_h;
      o_vcount      <= r_v;
      o_frame_start <= w_origin;
      o_busy        <= 1'b1;
    end else begin
      o_vid_data    <= '0;
      o_vid_hsync   <= !SYNC_POL;
      o_vid_vsync   <= !SYNC_POL;
      o_vid_VDE     <= 1'b0;
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_frame_start <= 1'b0;
      o_busy        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb/tb_vid_timing_gen.sv - self-checking bench for vid_timing_gen on a reduced raster
module tb_vid_timing_gen;

  localparam int HA = 128, HFP = 6, HSW = 6, HBP = 10;
  localparam int VA = 70,  VFP = 2, VSW = 2, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;   // 150
  localparam int VT = VA + VFP + VSW + VBP;   // 76
  localparam int FRAME = HT * VT;             // 11400
  localparam bit SP = 1'b1;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        i_en = 1'b0;
  logic [3:0]  sw = 4'b0000;
  logic [23:0] o_vid_data;
  logic        o_vid_hsync, o_vid_vsync, o_vid_VDE;
  logic [11:0] o_hcount;
  logic [10:0] o_vcount;
  logic        o_frame_start, o_busy;

  vid_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(SP)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_en(i_en), .sw(sw),
    .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync), .o_vid_vsync(o_vid_vsync),
    .o_vid_VDE(o_vid_VDE), .o_hcount(o_hcount), .o_vcount(o_vcount),
    .o_frame_start(o_frame_start), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Beat-level model: a running frame emits linear beat numbers 0..FRAME-1;
  // at the end of a frame the generator carries on only if i_en is high.
  logic       m_run;
  int         m_pos;
  logic [1:0] m_sel;
  logic       e_busy;
  int         e_pos;
  logic [1:0] e_bsel;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_run  <= 1'b0;
      m_pos  <= 0;
      m_sel  <= 2'd0;
      e_busy <= 1'b0;
      e_pos  <= 0;
      e_bsel <= 2'd0;
    end else if (m_run) begin
      e_busy <= 1'b1;
      e_pos  <= m_pos;
      e_bsel <= (m_pos == 0) ? sw[1:0] : m_sel;
      m_sel  <= (m_pos == 0) ? sw[1:0] : m_sel;
      if (m_pos == FRAME - 1) begin
        m_pos <= 0;
        m_run <= i_en;
      end else begin
        m_pos <= m_pos + 1;
      end
    end else begin
      e_busy <= 1'b0;
      e_pos  <= 0;
      if (i_en) m_run <= 1'b1;
    end
  end

  int bar_r [8] = '{255, 255,   0,   0, 255, 255,   0, 0};
  int bar_g [8] = '{255, 255, 255, 255,   0,   0,   0, 0};
  int bar_b [8] = '{255,   0, 255,   0, 255,   0, 255, 0};

  function automatic logic [23:0] rgb24(input int r, input int g, input int b);
    return 24'((r << 16) | (b << 8) | g);
  endfunction

  function automatic logic [23:0] pix(input int h, input int v, input logic [1:0] sel);
    logic [23:0] d;
    int k, g;
    d = 24'h0;
    case (sel)
      2'd0: begin
        k = h / (HA / 8);
        d = rgb24(bar_r[k], bar_g[k], bar_b[k]);
      end
      2'd1: begin
        g = (h / 8) % 256;
        d = rgb24(g, g, g);
      end
      2'd2: d = rgb24(128, 128, 128);
      default: d = (((h / 64) % 2) != ((v / 64) % 2)) ? rgb24(255, 255, 255) : 24'h0;
    endcase
`ifdef VID_TIMING_GEN_CROSSHAIR_EN
    if (h == HA / 2 || v == VA / 2) d = rgb24(255, 0, 0);
`endif
    return d;
  endfunction

  // {data[51:28], hsync, vsync, vde, h[24:13], v[12:2], frame_start, busy}
  function automatic logic [51:0] exp_vec(input logic busy, input int pos, input logic [1:0] sel);
    int h, v;
    logic vde, hs, vs;
    logic [23:0] d;
    if (!busy) return {24'h0, ~SP, ~SP, 1'b0, 12'h0, 11'h0, 1'b0, 1'b0};
    h   = pos % HT;
    v   = pos / HT;
    vde = (h < HA) && (v < VA);
    hs  = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs  = (v >= VA + VFP) && (v < VA + VFP + VSW);
    d   = vde ? pix(h, v, sel) : 24'h0;
    return {d, SP ? hs : ~hs, SP ? vs : ~vs, vde, 12'(h), 11'(v), (pos == 0), 1'b1};
  endfunction

  function automatic logic [23:0] model_data();
    logic [51:0] t;
    t = exp_vec(e_busy, e_pos, e_bsel);
    return t[51:28];
  endfunction

  // Per-cycle compare against the model.
  initial begin
    logic [51:0] act, exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp = exp_vec(e_busy, e_pos, e_bsel);
        act = {o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE, o_hcount, o_vcount,
               o_frame_start, o_busy};
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL per_cycle cyc=%0d got=%h expected=%h (data hs vs vde h v fs busy)",
                      cyc, act, exp);
      end
    end
  end

  // Raster statistics measured from the DUT outputs.
  int fs_last = 0, fs_prev = 0, vde_cnt = 0, vde_last = 0;
  int hs_run = 0, hs_len = 0, hs_start = -1;
  int vs_run = 0, vs_len = 0, vs_start = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (o_frame_start) begin
        fs_prev  = fs_last;
        fs_last  = cyc;
        vde_last = vde_cnt;
        vde_cnt  = 1;
      end else if (o_vid_VDE) begin
        vde_cnt++;
      end
      if (o_vid_hsync) begin
        if (hs_run == 0) hs_start = int'(o_hcount);
        hs_run++;
      end else if (hs_run != 0) begin
        hs_len = hs_run;
        hs_run = 0;
      end
      if (o_vid_vsync) begin
        if (vs_run == 0) vs_start = int'(o_vcount);
        vs_run++;
      end else if (vs_run != 0) begin
        vs_len = vs_run;
        vs_run = 0;
      end
    end
  end

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic at_beat(input int h, input int v);
    int n, tgt;
    tgt = v * HT + h;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(e_busy && e_pos == tgt) && n < 20000);
    if (!(e_busy && e_pos == tgt)) begin
      n_total++;
      $display("FAIL wait_beat_%0d_%0d: not reached after %0d cycles", h, v, n);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    lit("rst_busy", 32'(o_busy), 32'd0);
    lit("rst_data", 32'(o_vid_data), 32'h0);
    lit("rst_hcount", 32'(o_hcount), 32'd0);
    lit("rst_hsync", 32'(o_vid_hsync), 32'd0);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    lit("idle_busy", 32'(o_busy), 32'd0);

    // Frame A: colour bars (reserved sw bits set to show they are ignored).
    sw = 4'b1000;
    i_en = 1'b1;
    at_beat(0, 0);
    lit("A_fs", 32'(o_frame_start), 32'd1);
    lit("A_white", 32'(o_vid_data), 32'hFFFFFF);
    lit("A_vde0", 32'(o_vid_VDE), 32'd1);
    at_beat(30, 0);
    lit("A_yellow", 32'(o_vid_data), 32'hFF00FF);
    lit("model_yellow", 32'(model_data()), 32'hFF00FF);
    at_beat(128, 0);
    lit("A_blank_vde", 32'(o_vid_VDE), 32'd0);
    lit("A_blank_data", 32'(o_vid_data), 32'h0);
    sw = 4'b0101;

    // Frame B: grey ramp, switch to checkerboard mid-frame.
    at_beat(0, 0);
    #1;
    lit("frame_interval_AB", 32'(fs_last - fs_prev), 32'd11400);
    lit("vde_beats_A", 32'(vde_last), 32'd8960);
    lit("hsync_len", 32'(hs_len), 32'd6);
    lit("hsync_start_h", 32'(hs_start), 32'd134);
    lit("vsync_len", 32'(vs_len), 32'd300);
    lit("vsync_start_v", 32'(vs_start), 32'd72);
    at_beat(100, 5);
    lit("B_ramp", 32'(o_vid_data), 32'h0C0C0C);
    lit("model_ramp", 32'(model_data()), 32'h0C0C0C);
    at_beat(0, 10);
    sw = 4'b0011;
    at_beat(100, 20);
    lit("B_ramp_after_sw", 32'(o_vid_data), 32'h0C0C0C);

    // Frame C: checkerboard; drop and restore i_en during the frame.
    at_beat(64, 0);
`ifdef VID_TIMING_GEN_CROSSHAIR_EN
    lit("C_chk_64_0", 32'(o_vid_data), 32'hFF0000);
    lit("model_chk_64_0", 32'(model_data()), 32'hFF0000);
`else
    lit("C_chk_64_0", 32'(o_vid_data), 32'hFFFFFF);
    lit("model_chk_64_0", 32'(model_data()), 32'hFFFFFF);
`endif
    at_beat(0, 35);
    i_en = 1'b0;
    at_beat(0, 50);
    lit("C_drain_busy", 32'(o_busy), 32'd1);
    i_en = 1'b1;
    at_beat(64, 64);
`ifdef VID_TIMING_GEN_CROSSHAIR_EN
    lit("C_chk_64_64", 32'(o_vid_data), 32'hFF0000);
`else
    lit("C_chk_64_64", 32'(o_vid_data), 32'h000000);
`endif
    sw = 4'b0010;

    // Frame D: mid-grey, then drain to idle.
    at_beat(0, 0);
    #1;
    lit("frame_interval_CD", 32'(fs_last - fs_prev), 32'd11400);
    at_beat(63, 10);
    lit("D_grey_63", 32'(o_vid_data), 32'h808080);
    at_beat(64, 10);
`ifdef VID_TIMING_GEN_CROSSHAIR_EN
    lit("D_cross_64", 32'(o_vid_data), 32'hFF0000);
`else
    lit("D_cross_64", 32'(o_vid_data), 32'h808080);
`endif
    at_beat(0, 35);
    i_en = 1'b0;
    at_beat(149, 75);
    lit("D_last_busy", 32'(o_busy), 32'd1);
    lit("D_last_h", 32'(o_hcount), 32'd149);
    lit("D_last_v", 32'(o_vcount), 32'd75);
    @(negedge clk);
    lit("D_idle_busy", 32'(o_busy), 32'd0);
    lit("D_idle_h", 32'(o_hcount), 32'd0);
    lit("D_idle_vde", 32'(o_vid_VDE), 32'd0);
    repeat (20) @(negedge clk);
    lit("D_idle_hold", 32'(o_busy), 32'd0);

    // Restart, then reset in the middle of the frame.
    i_en = 1'b1;
    at_beat(70, 30);
    #2;
    n_rst = 1'b0;
    #1;
    lit("async_rst_data", 32'(o_vid_data), 32'h0);
    lit("async_rst_h", 32'(o_hcount), 32'd0);
    lit("async_rst_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    at_beat(0, 0);
    lit("restart_fs", 32'(o_frame_start), 32'd1);
    lit("restart_data", 32'(o_vid_data), 32'h808080);
    lit("restart_h", 32'(o_hcount), 32'd0);
    repeat (200) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
